// File: rtl/net_sched_pkg.sv
// Shared types and default widths for the mux_network timestep scheduler.
package net_sched_pkg;

   localparam int unsigned Q_DATA_WIDTH   = 2;
   localparam int unsigned Q_SIZE         = 1024;
   localparam int unsigned SPIKE_OUT_ADDR = 10;
   localparam int unsigned SPIKE_OUT_DATA = 2;
   localparam int unsigned STEP_W         = 16;
   localparam int unsigned TIMEOUT        = 2048;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FIRE,
      WAIT,
      FIN
   } state_t;

   typedef struct packed {
      logic [STEP_W-1:0]         step;
      logic [SPIKE_OUT_ADDR-1:0] addr;
      logic [SPIKE_OUT_DATA-1:0] data;
   } evt_data_t;

endpackage

// File: rtl/net_sched_evt_fmt.sv
// Registered spike filter/tagger: forwards non-zero network spikes tagged with the step index.
// Optional SCHED_STATS_EN adds a saturating forwarded-event counter.
module net_sched_evt_fmt #(
   parameter int unsigned STEP_W         = 16,
   parameter int unsigned SPIKE_OUT_ADDR = 10,
   parameter int unsigned SPIKE_OUT_DATA = 2
) (
   input  logic                                       clk,
   input  logic                                       reset,
`ifdef SCHED_STATS_EN
   input  logic                                       clr,
   output logic [STEP_W+SPIKE_OUT_ADDR:0]             evt_count,
`endif
   input  logic                                       in_wait,
   input  logic [STEP_W-1:0]                          step,
   input  logic [SPIKE_OUT_ADDR+SPIKE_OUT_DATA-1:0]   net_spike,
   output logic                                       evt_valid,
   output logic [STEP_W+SPIKE_OUT_ADDR+SPIKE_OUT_DATA-1:0] evt_data
);

   logic hit;

   // A zero data field means "no spike" for that address.
   assign hit = in_wait && (net_spike[SPIKE_OUT_DATA-1:0] != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         evt_valid <= 1'b0;
         evt_data  <= '0;
      end else begin
         evt_valid <= hit;
         if (hit) begin
            evt_data <= {step, net_spike};
         end
      end
   end

`ifdef SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         evt_count <= '0;
      end else if (clr) begin
         evt_count <= '0;
      end else if (hit && (evt_count != '1)) begin
         evt_count <= evt_count + (STEP_W+SPIKE_OUT_ADDR+1)'(1);
      end
   end
`endif

endmodule

// File: rtl/network_step_scheduler.sv
// Timestep sequencer: load spike vector, pulse mux_network, forward spikes, wait for done.
// Optional SCHED_STATS_EN exposes evt_count (forwarded events in the current/last run).
module network_step_scheduler #(
   parameter int unsigned Q_DATA_WIDTH   = net_sched_pkg::Q_DATA_WIDTH,
   parameter int unsigned Q_SIZE         = net_sched_pkg::Q_SIZE,
   parameter int unsigned SPIKE_OUT_ADDR = net_sched_pkg::SPIKE_OUT_ADDR,
   parameter int unsigned SPIKE_OUT_DATA = net_sched_pkg::SPIKE_OUT_DATA,
   parameter int unsigned STEP_W         = net_sched_pkg::STEP_W,
   parameter int unsigned TIMEOUT        = net_sched_pkg::TIMEOUT
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       start,
   input  logic                                       abort,
   input  logic [STEP_W-1:0]                          cfg_num_steps,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       timeout_err,
   output logic                                       q_rd_en,
   input  logic                                       q_valid,
   input  logic [Q_DATA_WIDTH*Q_SIZE-1:0]             q_data,
   output logic                                       en_network,
   output logic [Q_DATA_WIDTH*Q_SIZE-1:0]             spike_in,
   input  logic                                       net_done,
   input  logic [SPIKE_OUT_ADDR+SPIKE_OUT_DATA-1:0]   net_spike,
   output logic                                       evt_valid,
   output logic [STEP_W+SPIKE_OUT_ADDR+SPIKE_OUT_DATA-1:0] evt_data,
`ifdef SCHED_STATS_EN
   output logic [STEP_W+SPIKE_OUT_ADDR:0]             evt_count,
`endif
   output logic [STEP_W-1:0]                          step_cnt
);

   import net_sched_pkg::*;

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t            state;
   logic [STEP_W-1:0] num_steps;
   logic [TW-1:0]     tmo_cnt;
   logic              in_wait;

   assign in_wait = (state == WAIT) && !abort;

   // Sequencer; every output is registered so the transition sets next-cycle values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         q_rd_en     <= 1'b0;
         en_network  <= 1'b0;
         spike_in    <= '0;
         step_cnt    <= '0;
         num_steps   <= '0;
         tmo_cnt     <= '0;
      end else if (abort) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         q_rd_en    <= 1'b0;
         en_network <= 1'b0;
      end else begin
         done       <= 1'b0;
         en_network <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  num_steps   <= cfg_num_steps;
                  step_cnt    <= '0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  if (cfg_num_steps == '0) begin
                     state <= FIN;
                  end else begin
                     state   <= LOAD;
                     q_rd_en <= 1'b1;
                  end
               end
            end
            LOAD: begin
               // q_rd_en is always high here, so q_valid alone marks an accepted vector.
               if (q_valid) begin
                  spike_in   <= q_data;
                  q_rd_en    <= 1'b0;
                  en_network <= 1'b1;
                  state      <= FIRE;
               end
            end
            FIRE: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               if (net_done) begin
                  if (step_cnt == num_steps - STEP_W'(1)) begin
                     state <= FIN;
                  end else begin
                     step_cnt <= step_cnt + STEP_W'(1);
                     q_rd_en  <= 1'b1;
                     state    <= LOAD;
                  end
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= FIN;
               end
            end
            FIN: begin
               // timeout_err was cleared at start, so it is set here only after a timeout.
               done  <= !timeout_err;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SCHED_STATS_EN
   logic start_ok;
   assign start_ok = (state == IDLE) && start && !abort;
`endif

   net_sched_evt_fmt #(
      .STEP_W         (STEP_W),
      .SPIKE_OUT_ADDR (SPIKE_OUT_ADDR),
      .SPIKE_OUT_DATA (SPIKE_OUT_DATA)
   ) u_evt_fmt (
      .clk       (clk),
      .reset     (reset),
`ifdef SCHED_STATS_EN
      .clr       (start_ok),
      .evt_count (evt_count),
`endif
      .in_wait   (in_wait),
      .step      (step_cnt),
      .net_spike (net_spike),
      .evt_valid (evt_valid),
      .evt_data  (evt_data)
   );

endmodule

// File: tb/tb_network_step_scheduler.sv
// Self-checking bench for network_step_scheduler (short TIMEOUT instance, randomized runs).
module tb_network_step_scheduler;

   import net_sched_pkg::*;

   localparam int unsigned TMO = 16;
   localparam int unsigned QW  = Q_DATA_WIDTH * Q_SIZE;
   localparam int unsigned NW  = SPIKE_OUT_ADDR + SPIKE_OUT_DATA;
   localparam int unsigned EW  = STEP_W + NW;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [STEP_W-1:0] cfg_num_steps = '0;
   logic              busy, done, timeout_err, q_rd_en, en_network, evt_valid;
   logic              q_valid = 1'b0;
   logic [QW-1:0]     q_data = '0;
   logic [QW-1:0]     spike_in;
   logic              net_done = 1'b0;
   logic [NW-1:0]     net_spike = '0;
   logic [EW-1:0]     evt_data;
   logic [STEP_W-1:0] step_cnt;
`ifdef SCHED_STATS_EN
   logic [STEP_W+SPIKE_OUT_ADDR:0] evt_count;
`endif

   int total = 0;
   int bad   = 0;

   // Transaction monitor: counts pulses/consumptions and records forwarded events.
   int        n_en = 0, n_cons = 0, n_done = 0;
   evt_data_t act_q[$];

   network_step_scheduler #(.TIMEOUT(TMO)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .cfg_num_steps (cfg_num_steps),
      .busy          (busy),
      .done          (done),
      .timeout_err   (timeout_err),
      .q_rd_en       (q_rd_en),
      .q_valid       (q_valid),
      .q_data        (q_data),
      .en_network    (en_network),
      .spike_in      (spike_in),
      .net_done      (net_done),
      .net_spike     (net_spike),
      .evt_valid     (evt_valid),
      .evt_data      (evt_data),
`ifdef SCHED_STATS_EN
      .evt_count     (evt_count),
`endif
      .step_cnt      (step_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset) begin
         if (en_network)          n_en   <= n_en + 1;
         if (q_rd_en && q_valid)  n_cons <= n_cons + 1;
         if (done)                n_done <= n_done + 1;
         if (evt_valid)           act_q.push_back(evt_data_t'(evt_data));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [QW-1:0] rand_vec();
      logic [QW-1:0] v;
      for (int i = 0; i < int'(QW / 32); i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // One complete run; mode 1 drives the fixed step-1 spike pattern, mode 0 random spikes.
   task automatic do_run(input int n, input int dly, input int stall, input int mode, input string nm);
      int            en0, cons0, done0, ev0, last;
      evt_data_t     exp_q[$];
      logic [QW-1:0] v;
      logic [NW-1:0] sp;
      en0 = n_en; cons0 = n_cons; done0 = n_done; ev0 = act_q.size();
      cfg_num_steps = STEP_W'(n); start = 1'b1;
      tick();
      start = 1'b0; cfg_num_steps = STEP_W'($urandom());
      total++;
      if (busy !== 1'b1 || timeout_err !== 1'b0)
         begin bad++; $display("FAIL %s start: busy=%b terr=%b want 1/0", nm, busy, timeout_err); end
      for (int s = 0; s < n; s++) begin
         total++;
         if (q_rd_en !== 1'b1 || step_cnt !== STEP_W'(s))
            begin bad++; $display("FAIL %s load s%0d: rd=%b step=%0d want 1/%0d", nm, s, q_rd_en, step_cnt, s); end
         for (int k = 0; k < stall; k++) begin
            q_valid = 1'b0;
            tick();
            total++;
            if (q_rd_en !== 1'b1 || en_network !== 1'b0)
               begin bad++; $display("FAIL %s stall: rd=%b en=%b want 1/0", nm, q_rd_en, en_network); end
         end
         v = rand_vec(); q_valid = 1'b1; q_data = v;
         tick();
         q_valid = 1'b0; q_data = rand_vec();
         total++;
         if (en_network !== 1'b1 || q_rd_en !== 1'b0 || spike_in !== v)
            begin bad++; $display("FAIL %s fire s%0d: en=%b rd=%b vec_ok=%b want 1/0/1", nm, s, en_network, q_rd_en, spike_in === v); end
         tick();
         for (int w = 0; w < dly; w++) begin
            total++;
            if (en_network !== 1'b0 || busy !== 1'b1)
               begin bad++; $display("FAIL %s wait: en=%b busy=%b want 0/1", nm, en_network, busy); end
            if (mode == 1)
               sp = (s == 1 && w == 0) ? NW'({10'h005, 2'b01}) :
                    (s == 1 && w == 1) ? NW'({10'h006, 2'b00}) : '0;
            else
               sp = NW'($urandom());
            if (sp[SPIKE_OUT_DATA-1:0] != '0) exp_q.push_back(evt_data_t'({STEP_W'(s), sp}));
            net_spike = sp;
            net_done  = (w == dly - 1);
            if (mode == 0 && s == 0 && w == 0) start = 1'b1;
            tick();
            start = 1'b0;
         end
         net_done = 1'b0; net_spike = '0;
      end
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || q_rd_en !== 1'b0)
         begin bad++; $display("FAIL %s fin: busy=%b done=%b rd=%b want 1/0/0", nm, busy, done, q_rd_en); end
      tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0)
         begin bad++; $display("FAIL %s done: done=%b busy=%b want 1/0", nm, done, busy); end
      tick();
      last = (n == 0) ? 0 : n - 1;
      total++;
      if (done !== 1'b0 || step_cnt !== STEP_W'(last))
         begin bad++; $display("FAIL %s end: done=%b step=%0d want 0/%0d", nm, done, step_cnt, last); end
      total++;
      if (n_en - en0 != n || n_cons - cons0 != n || n_done - done0 != 1)
         begin bad++; $display("FAIL %s counts: en=%0d cons=%0d done=%0d want %0d/%0d/1", nm, n_en - en0, n_cons - cons0, n_done - done0, n, n); end
      total++;
      if (act_q.size() - ev0 != exp_q.size())
         begin bad++; $display("FAIL %s evt_num: got=%0d want=%0d", nm, act_q.size() - ev0, exp_q.size()); end
      else
         for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (act_q[ev0 + i] !== exp_q[i])
               begin bad++; $display("FAIL %s evt%0d: got=%h want=%h", nm, i, act_q[ev0 + i], exp_q[i]); end
         end
`ifdef SCHED_STATS_EN
      total++;
      if (evt_count !== (STEP_W+SPIKE_OUT_ADDR+1)'(exp_q.size()))
         begin bad++; $display("FAIL %s evt_count: got=%0d want=%0d", nm, evt_count, exp_q.size()); end
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      total++;
      if ({busy, done, timeout_err, q_rd_en, en_network, evt_valid} !== 6'b0 ||
          spike_in !== '0 || evt_data !== '0 || step_cnt !== '0)
         begin bad++; $display("FAIL reset: ctl=%b step=%0d evt=%h", {busy, done, timeout_err, q_rd_en, en_network, evt_valid}, step_cnt, evt_data); end
   endtask

   task automatic test_timeout();
      int done0;
      done0 = n_done;
      cfg_num_steps = STEP_W'(2); start = 1'b1;
      tick();
      start = 1'b0; q_valid = 1'b1; q_data = rand_vec();
      tick();
      q_valid = 1'b0;
      tick();
      for (int w = 0; w < int'(TMO); w++) begin
         total++;
         if (timeout_err !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL tmo wait%0d: terr=%b busy=%b want 0/1", w, timeout_err, busy); end
         tick();
      end
      total++;
      if (timeout_err !== 1'b1 || done !== 1'b0 || busy !== 1'b1)
         begin bad++; $display("FAIL tmo fin: terr=%b done=%b busy=%b want 1/0/1", timeout_err, done, busy); end
      tick();
      tick();
      total++;
      if (timeout_err !== 1'b1 || busy !== 1'b0 || n_done != done0)
         begin bad++; $display("FAIL tmo after: terr=%b busy=%b dones=%0d want 1/0/0", timeout_err, busy, n_done - done0); end
      do_run(0, 1, 0, 0, "tmo_clear");
   endtask

   task automatic test_abort();
      int            en0, done0, ev0;
      logic [QW-1:0] v1;
      en0 = n_en; done0 = n_done; ev0 = act_q.size();
      cfg_num_steps = STEP_W'(3); start = 1'b1;
      tick();
      start = 1'b0; q_valid = 1'b1; q_data = rand_vec();
      tick();
      q_valid = 1'b0;
      tick();
      net_done = 1'b1;
      tick();
      net_done = 1'b0;
      total++;
      if (step_cnt !== STEP_W'(1) || q_rd_en !== 1'b1)
         begin bad++; $display("FAIL abort step1: step=%0d rd=%b want 1/1", step_cnt, q_rd_en); end
      v1 = rand_vec(); q_valid = 1'b1; q_data = v1;
      tick();
      q_valid = 1'b0;
      tick();
      net_spike = NW'({10'h005, 2'b11});
      tick();
      abort = 1'b1; start = 1'b1; cfg_num_steps = STEP_W'(5); net_spike = NW'({10'h007, 2'b10});
      tick();
      abort = 1'b0; start = 1'b0; net_spike = '0;
      total++;
      if (busy !== 1'b0 || en_network !== 1'b0 || q_rd_en !== 1'b0 || evt_valid !== 1'b0 ||
          step_cnt !== STEP_W'(1) || spike_in !== v1)
         begin bad++; $display("FAIL abort: busy=%b en=%b rd=%b ev=%b step=%0d vec_ok=%b", busy, en_network, q_rd_en, evt_valid, step_cnt, spike_in === v1); end
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if (busy !== 1'b0 || q_rd_en !== 1'b0 || en_network !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL abort idle%0d: busy=%b rd=%b en=%b done=%b", k, busy, q_rd_en, en_network, done); end
      end
      total++;
      if (n_en - en0 != 2 || n_done != done0 || act_q.size() - ev0 != 1)
         begin bad++; $display("FAIL abort counts: en=%0d done=%0d evts=%0d want 2/0/1", n_en - en0, n_done - done0, act_q.size() - ev0); end
      else begin
         total++;
         if (act_q[ev0] !== evt_data_t'({16'd1, 10'h005, 2'b11}))
            begin bad++; $display("FAIL abort evt: got=%h", act_q[ev0]); end
      end
   endtask

   task automatic test_reset_midrun();
      cfg_num_steps = STEP_W'(2); start = 1'b1;
      tick();
      start = 1'b0; q_valid = 1'b1; q_data = rand_vec();
      tick();
      q_valid = 1'b0;
      tick();
      net_spike = NW'({10'h033, 2'b01});
      tick();
      reset = 1'b1; net_spike = '0;
      tick();
      reset = 1'b0;
      total++;
      if ({busy, done, timeout_err, q_rd_en, en_network, evt_valid} !== 6'b0 ||
          spike_in !== '0 || evt_data !== '0 || step_cnt !== '0)
         begin bad++; $display("FAIL midrun reset: ctl=%b step=%0d evt=%h", {busy, done, timeout_err, q_rd_en, en_network, evt_valid}, step_cnt, evt_data); end
   endtask

   task automatic test_random_runs();
      for (int r = 0; r < 6; r++)
         do_run($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(0, 3), 0, "random");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      do_run(3, 4, 0, 0, "three_steps");
      do_run(0, 1, 0, 0, "zero_steps");
      do_run(2, 3, 0, 1, "spike_tag");
      do_run(2, 3, 5, 0, "q_stall");
      test_timeout();
      test_abort();
      test_reset_midrun();
      test_random_runs();
      do_run(1, 1, 0, 0, "back_to_back");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/network_step_scheduler.md
Name: network_step_scheduler

Overview:
Timestep sequencer for the mux_network spike-scan datapath. Per timestep it pulls one spike vector from the upstream spike queue and latches it onto the network's spike_in. It then pulses en_network, forwards each non-zero spike_out word tagged with the timestep, and waits for networkDone. It repeats for a configured number of steps and reports completion, abort or timeout to the host control logic.

Parameters:
Q_DATA_WIDTH, 2, bits per neuron spike entry
Q_SIZE, 1024, neurons per spike vector
SPIKE_OUT_ADDR, 10, address field width of network spike_out
SPIKE_OUT_DATA, 2, data field width of network spike_out
STEP_W, 16, timestep counter width
TIMEOUT, 2048, max cycles to wait for networkDone per step

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  run request; sampled in IDLE only
abort  in  1  cancel run; highest priority
cfg_num_steps  in  STEP_W  steps per run; captured on accepted start
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse on normal run completion
timeout_err  out  1  sticky; set on step timeout, cleared by next accepted start
q_rd_en  out  1  request next spike vector from queue
q_valid  in  1  queue vector present on q_data
q_data  in  Q_DATA_WIDTH*Q_SIZE  spike vector
en_network  out  1  1-cycle start pulse to mux_network
spike_in  out  Q_DATA_WIDTH*Q_SIZE  registered vector to mux_network
net_done  in  1  networkDone from mux_network
net_spike  in  SPIKE_OUT_ADDR+SPIKE_OUT_DATA  spike_out from mux_network
evt_valid  out  1  forwarded spike event valid
evt_data  out  STEP_W+SPIKE_OUT_ADDR+SPIKE_OUT_DATA  {step index, net_spike}
step_cnt  out  STEP_W  index of current or last step

Behaviour:
- Reset: state IDLE. Outputs busy, done, timeout_err, q_rd_en, en_network and evt_valid are 0. spike_in, evt_data and step_cnt are 0.
- FSM states: IDLE, LOAD, FIRE, WAIT, FIN.
- IDLE: on start:
  - capture cfg_num_steps, step_cnt<=0, clear timeout_err.
  - If cfg_num_steps==0, go to FIN; otherwise go to LOAD.
- LOAD:
  - q_rd_en=1 every cycle until q_valid.
  - On q_valid, spike_in<=q_data, q_rd_en drops the following cycle, go to FIRE.
  - Upstream consumes one vector per cycle in which q_rd_en && q_valid.
- FIRE: en_network=1 for exactly this cycle; timeout counter<=0; go to WAIT.
- WAIT:
  - Each cycle where net_spike data field != 0: evt_valid=1 and evt_data={step_cnt, net_spike}, registered, so the event appears 1 cycle after the spike.
  - Data field ==0 produces no event. There is no backpressure.
  - On net_done: if step_cnt==num_steps-1 go to FIN; else step_cnt++ and go to LOAD.
  - net_done is ignored outside WAIT.
  - If the counter reaches TIMEOUT-1 without net_done: set timeout_err and go to FIN.
- FIN: done=1 for one cycle only on normal completion (no done on timeout); go to IDLE; busy=0 from the next cycle.
- Latency:
  - start to first q_rd_en: 1 cycle.
  - Vector accept to en_network: 1 cycle.
  - net_done to next q_rd_en: 1 cycle.
- abort:
  - Any state goes to IDLE next cycle.
  - en_network, q_rd_en and evt_valid are forced 0 that cycle.
  - No done pulse; spike_in holds; step_cnt holds.
  - abort and start in the same cycle: abort wins, start is dropped.
- Other boundaries:
  - start while busy is ignored.
  - step_cnt stops at num_steps-1; no wrap within a run.
  - reset mid-run behaves like abort but also clears all registers.

Optional Feature:
SCHED_STATS_EN:
- Enabled: adds output evt_count [STEP_W+SPIKE_OUT_ADDR+1].
  - Cleared on accepted start; incremented per evt_valid; saturates at all-ones.
  - Held in IDLE.
- Disabled: port and counter absent; all other behaviour identical.

Decomposition:
- Package net_sched_pkg:
  - state enum (IDLE, LOAD, FIRE, WAIT, FIN).
  - Default widths: Q_DATA_WIDTH, Q_SIZE, SPIKE_OUT_ADDR, SPIKE_OUT_DATA, STEP_W.
  - TIMEOUT default.
  - Packed evt_data struct {step, addr, data}.
- Sub-module net_sched_evt_fmt: registered spike filter/tagger producing evt_valid/evt_data (and evt_count under SCHED_STATS_EN). The FSM stays in the top.

Test Plan:
- cfg_num_steps=3, q_valid always 1, net_done 4 cycles after each en_network:
  - exactly 3 en_network pulses and 3 vectors consumed;
  - step_cnt ends at 2; done pulses once; busy low after.
- cfg_num_steps=0, start -> done 2 cycles after start; no q_rd_en, no en_network.
- net_spike={10'h005,2'b01} then {10'h006,2'b00} during step 1:
  - one evt_valid with evt_data={16'd1,10'h005,2'b01};
  - no event for the zero data field.
- TIMEOUT=16, net_done never asserted -> timeout_err=1 after 16 WAIT cycles; FIN; no done; next start clears timeout_err.
- abort asserted in WAIT of step 1 with start the same cycle -> IDLE next cycle; no done; start ignored; en_network stays 0.
- q_valid held low 5 cycles in LOAD -> q_rd_en stays high; en_network waits until 1 cycle after q_valid; spike_in equals the q_data sampled then.
